// File: rtl/vanilla_inst_encoder_pkg.sv
// Shared types, encoding constants and field-pack helpers for the vanilla instruction encoder.
// Note: the package is named bsg_vanilla_pkg, so the other files use import bsg_vanilla_pkg::*.
package bsg_vanilla_pkg;

    localparam int reg_addr_width_p = 5;
    localparam int csr_addr_width_p = 12;

    typedef enum logic [3:0] {
        e_enc_li,
        e_enc_lw,
        e_enc_sw,
        e_enc_csrrw,
        e_enc_amoswap,
        e_enc_amoor,
        e_enc_amoadd,
        e_enc_fence,
        e_enc_barsend,
        e_enc_barrecv,
        e_enc_mret
    } enc_op_e;

    typedef struct packed {
        enc_op_e                       op;
        logic [reg_addr_width_p-1:0]   rd;
        logic [reg_addr_width_p-1:0]   rs1;
        logic [reg_addr_width_p-1:0]   rs2;
        logic [31:0]                   imm32;
        logic [csr_addr_width_p-1:0]   csr;
        logic                          aq;
        logic                          rl;
    } enc_cmd_s;

    localparam logic [6:0] op_load_c   = 7'b0000011;
    localparam logic [6:0] op_store_c  = 7'b0100011;
    localparam logic [6:0] op_imm_c    = 7'b0010011;
    localparam logic [6:0] op_lui_c    = 7'b0110111;
    localparam logic [6:0] op_system_c = 7'b1110011;
    localparam logic [6:0] op_amo_c    = 7'b0101111;

    localparam logic [2:0] f3_addi_c  = 3'b000;
    localparam logic [2:0] f3_csrrw_c = 3'b001;
    localparam logic [2:0] f3_word_c  = 3'b010;

    localparam logic [4:0] f5_amoswap_c = 5'b00001;
    localparam logic [4:0] f5_amoor_c   = 5'b01000;
    localparam logic [4:0] f5_amoadd_c  = 5'b00000;

    localparam logic [3:0] fm_barsend_c = 4'b0001;
    localparam logic [3:0] fm_barrecv_c = 4'b0010;

    localparam logic [31:0] fence_instr_c = 32'h0FF0000F;
    localparam logic [31:0] mret_instr_c  = 32'h30200073;

    function automatic logic [31:0] pack_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                           logic [4:0] rd, logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] pack_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                           logic [2:0] f3, logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    function automatic logic [31:0] pack_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] pack_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                           logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic fits_simm12(logic [31:0] imm);
        return imm[31:11] == {21{imm[11]}};
    endfunction

endpackage

// File: rtl/vanilla_inst_encoder_if.sv
// Command-in / instruction-out stream bundle of the vanilla instruction encoder.
interface vanilla_inst_encoder_if;
    import bsg_vanilla_pkg::*;

    logic        v_i;
    enc_cmd_s    cmd_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] instr_o;
    logic        yumi_i;
    logic        last_o;
    logic        error_o;

    modport slave  (input  v_i, cmd_i, yumi_i,
                    output ready_o, v_o, instr_o, last_o, error_o);
    modport master (output v_i, cmd_i, yumi_i,
                    input  ready_o, v_o, instr_o, last_o, error_o);
endinterface

// File: rtl/vanilla_inst_encoder_pack.sv
// Combinational command-to-word packer; word_sel_i picks the second LI word.
// VANILLA_INST_ENC_LI_SHORT_EN lets LI collapse to a single ADDI or LUI when possible.
module vanilla_inst_pack
    import bsg_vanilla_pkg::*;
(
    input  enc_cmd_s    cmd_i,
    input  logic        word_sel_i,
    output logic [31:0] instr_o,
    output logic        is_last_o,
    output logic        illegal_o
);

    logic [19:0] li_upper;
    logic        li_short_addi;
    logic        li_short_lui;

    // ADDI sign-extends its immediate, so the LUI half is pre-biased by imm[11].
    assign li_upper = cmd_i.imm32[31:12] + {19'b0, cmd_i.imm32[11]};

`ifdef VANILLA_INST_ENC_LI_SHORT_EN
    assign li_short_addi = fits_simm12(cmd_i.imm32);
    assign li_short_lui  = ~li_short_addi & (cmd_i.imm32[11:0] == 12'b0);
`else
    assign li_short_addi = 1'b0;
    assign li_short_lui  = 1'b0;
`endif

    always_comb begin
        instr_o   = '0;
        is_last_o = 1'b1;
        illegal_o = 1'b0;
        case (cmd_i.op)
            e_enc_li: begin
                if (li_short_addi) begin
                    instr_o = pack_i(cmd_i.imm32[11:0], 5'b0, f3_addi_c, cmd_i.rd, op_imm_c);
                end else if (li_short_lui || !word_sel_i) begin
                    instr_o   = pack_u(li_upper, cmd_i.rd, op_lui_c);
                    is_last_o = li_short_lui;
                end else begin
                    instr_o = pack_i(cmd_i.imm32[11:0], cmd_i.rd, f3_addi_c, cmd_i.rd, op_imm_c);
                end
            end
            e_enc_lw: begin
                instr_o   = pack_i(cmd_i.imm32[11:0], cmd_i.rs1, f3_word_c, cmd_i.rd, op_load_c);
                illegal_o = ~fits_simm12(cmd_i.imm32);
            end
            e_enc_sw: begin
                instr_o   = pack_s(cmd_i.imm32[11:0], cmd_i.rs2, cmd_i.rs1, f3_word_c, op_store_c);
                illegal_o = ~fits_simm12(cmd_i.imm32);
            end
            e_enc_csrrw:   instr_o = pack_i(cmd_i.csr, cmd_i.rs1, f3_csrrw_c, cmd_i.rd, op_system_c);
            e_enc_amoswap: instr_o = pack_r({f5_amoswap_c, cmd_i.aq, cmd_i.rl}, cmd_i.rs2, cmd_i.rs1,
                                            f3_word_c, cmd_i.rd, op_amo_c);
            e_enc_amoor:   instr_o = pack_r({f5_amoor_c, cmd_i.aq, cmd_i.rl}, cmd_i.rs2, cmd_i.rs1,
                                            f3_word_c, cmd_i.rd, op_amo_c);
            e_enc_amoadd:  instr_o = pack_r({f5_amoadd_c, cmd_i.aq, cmd_i.rl}, cmd_i.rs2, cmd_i.rs1,
                                            f3_word_c, cmd_i.rd, op_amo_c);
            e_enc_fence:   instr_o = fence_instr_c;
            e_enc_barsend: instr_o = {fm_barsend_c, fence_instr_c[27:0]};
            e_enc_barrecv: instr_o = {fm_barrecv_c, fence_instr_c[27:0]};
            e_enc_mret:    instr_o = mret_instr_c;
            default:       illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/vanilla_inst_encoder.sv
// Encodes abstract commands into RV32 words on a registered valid/yumi stream.
// Optional macro VANILLA_INST_ENC_LI_SHORT_EN (single-word LI) is handled in vanilla_inst_pack.
module vanilla_inst_encoder
    import bsg_vanilla_pkg::*;
(
    input logic                   clk_i,
    input logic                   reset_n_i,
    vanilla_inst_encoder_if.slave bus
);

    typedef enum logic [1:0] {e_idle, e_word0, e_word1} state_e;

    state_e      state_q, state_d;
    logic        v_q, v_d;
    logic        last_q, last_d;
    logic        error_q, error_d;
    logic [31:0] instr_q, instr_d;
    enc_cmd_s    cmd_q, cmd_d;

    logic        hold_li;
    logic        accept;
    enc_cmd_s    pack_cmd;
    logic [31:0] pack_instr;
    logic        pack_last;
    logic        pack_illegal;

    // While the LUI half of an LI is held, the packer works on the stored command.
    assign hold_li  = (state_q == e_word0) & v_q & ~last_q;
    assign pack_cmd = hold_li ? cmd_q : bus.cmd_i;

    assign bus.ready_o = ~v_q | (v_q & last_q & bus.yumi_i);
    assign accept      = bus.v_i & bus.ready_o;

    vanilla_inst_pack u_pack (
        .cmd_i      (pack_cmd),
        .word_sel_i (hold_li),
        .instr_o    (pack_instr),
        .is_last_o  (pack_last),
        .illegal_o  (pack_illegal)
    );

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        last_d  = last_q;
        instr_d = instr_q;
        cmd_d   = cmd_q;
        error_d = 1'b0;
        if (hold_li && bus.yumi_i) begin
            state_d = e_word1;
            instr_d = pack_instr;
            last_d  = pack_last;
        end else begin
            if (v_q && bus.yumi_i) begin
                state_d = e_idle;
                v_d     = 1'b0;
                last_d  = 1'b0;
            end
            if (accept) begin
                if (pack_illegal) begin
                    error_d = 1'b1;
                end else begin
                    state_d = e_word0;
                    v_d     = 1'b1;
                    last_d  = pack_last;
                    instr_d = pack_instr;
                    cmd_d   = bus.cmd_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            v_q     <= 1'b0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
            instr_q <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            last_q  <= last_d;
            error_q <= error_d;
            instr_q <= instr_d;
            cmd_q   <= cmd_d;
        end
    end

    assign bus.v_o     = v_q;
    assign bus.instr_o = instr_q;
    assign bus.last_o  = last_q;
    assign bus.error_o = error_q;

endmodule

// File: tb/tb_vanilla_inst_encoder.sv
// Self-checking bench for vanilla_inst_encoder: directed encodings plus a randomized
// command stream scored against an arithmetic reference model.
module tb_vanilla_inst_encoder;
    import bsg_vanilla_pkg::*;

    typedef struct {
        logic [31:0] word;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    exp_t        exp_q[$];
    enc_cmd_s    pend_cmds[$];
    bit          err_pending;
    logic [31:0] obs_words[$];
    bit          obs_last[$];
    int          obs_cycle[$];
    int          obs_errs;

    always #5 clk = ~clk;

    vanilla_inst_encoder_if bus();

    vanilla_inst_encoder dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic void pushExp(input logic [31:0] w, input bit l);
        exp_t e;
        e.word = w;
        e.last = l;
        exp_q.push_back(e);
    endfunction

    // Reference encoder built from field positions with shifts and masks.
    function automatic void modelCmd(input enc_cmd_s c);
        logic [31:0] imm, rd, rs1, rs2, lo12, upper, lui, addi, f5;
        int          simm;
        imm   = c.imm32;
        rd    = 32'(c.rd);
        rs1   = 32'(c.rs1);
        rs2   = 32'(c.rs2);
        lo12  = imm & 32'hFFF;
        simm  = $signed(c.imm32);
        upper = ((imm >> 12) + ((imm >> 11) & 32'h1)) & 32'hFFFFF;
        lui   = (upper << 12) | (rd << 7) | 32'h37;
        addi  = (lo12 << 20) | (rd << 15) | (rd << 7) | 32'h13;
        f5    = 0;
        case (c.op)
            e_enc_li: begin
`ifdef VANILLA_INST_ENC_LI_SHORT_EN
                if (simm >= -2048 && simm <= 2047) pushExp((lo12 << 20) | (rd << 7) | 32'h13, 1'b1);
                else if (lo12 == 0) pushExp(lui, 1'b1);
                else begin
                    pushExp(lui, 1'b0);
                    pushExp(addi, 1'b1);
                end
`else
                pushExp(lui, 1'b0);
                pushExp(addi, 1'b1);
`endif
            end
            e_enc_lw, e_enc_sw: begin
                if (simm < -2048 || simm > 2047) err_pending = 1'b1;
                else if (c.op == e_enc_lw)
                    pushExp((lo12 << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03, 1'b1);
                else
                    pushExp((((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                            | ((imm & 32'h1F) << 7) | 32'h23, 1'b1);
            end
            e_enc_csrrw:
                pushExp((32'(c.csr) << 20) | (rs1 << 15) | (32'd1 << 12) | (rd << 7) | 32'h73, 1'b1);
            e_enc_amoswap, e_enc_amoor, e_enc_amoadd: begin
                f5 = (c.op == e_enc_amoswap) ? 32'd1 : (c.op == e_enc_amoor) ? 32'd8 : 32'd0;
                pushExp((f5 << 27) | (32'(c.aq) << 26) | (32'(c.rl) << 25) | (rs2 << 20) | (rs1 << 15)
                        | (32'd2 << 12) | (rd << 7) | 32'h2F, 1'b1);
            end
            e_enc_fence:   pushExp(32'h0FF0000F, 1'b1);
            e_enc_barsend: pushExp(32'h1FF0000F, 1'b1);
            e_enc_barrecv: pushExp(32'h2FF0000F, 1'b1);
            e_enc_mret:    pushExp(32'h30200073, 1'b1);
            default:       err_pending = 1'b1;
        endcase
    endfunction

    function automatic enc_cmd_s mkCmd(input enc_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] imm,
                                       input logic aq, input logic rl);
        enc_cmd_s c;
        c.op = op; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2;
        c.imm32 = imm; c.csr = '0; c.aq = aq; c.rl = rl;
        return c;
    endfunction

    function automatic enc_cmd_s randCmd();
        enc_cmd_s    c;
        logic [31:0] r;
        logic [11:0] s;
        r = $urandom;
        s = 12'($urandom);
        if ($urandom_range(0, 9) == 0) c.op = enc_op_e'(4'($urandom_range(11, 15)));
        else c.op = enc_op_e'(4'($urandom_range(0, 10)));
        c.rd  = 5'($urandom);
        c.rs1 = 5'($urandom);
        c.rs2 = 5'($urandom);
        c.csr = 12'($urandom);
        c.aq  = 1'($urandom);
        c.rl  = 1'($urandom);
        case ($urandom_range(0, 6))
            0:       c.imm32 = r;
            1:       c.imm32 = {{20{s[11]}}, s};
            2:       c.imm32 = {r[31:12], 12'h000};
            3:       c.imm32 = 32'h00000800;
            4:       c.imm32 = 32'hFFFFF7FF;
            5:       c.imm32 = 32'h000007FF;
            default: c.imm32 = 32'hFFFFF800;
        endcase
        return c;
    endfunction

    function automatic void clearObs();
        obs_words.delete();
        obs_last.delete();
        obs_cycle.delete();
        obs_errs = 0;
    endfunction

    task automatic checkObs(input string tag, input int idx, input logic [31:0] word, input bit last);
        if (idx < obs_words.size()) begin
            checkOutput(tag, obs_words[idx], word);
            checkOutput({tag, "_last"}, 32'(obs_last[idx]), 32'(last));
        end else begin
            checkOutput({tag, "_missing"}, 32'(obs_words.size()), 32'(idx + 1));
        end
    endtask

    // Cycle engine: entered and left #1 after a rising edge; checks at the falling edge.
    task automatic applyStimulus(input int yumi_pct, input int vgap_pct, input int stall, input int budget);
        int stall_left = stall;
        int cyc = 0;
        bit rdy_exp;
        while ((pend_cmds.size() != 0 || exp_q.size() != 0 || err_pending) && cyc < budget) begin
            bus.v_i   = (pend_cmds.size() != 0) && ($urandom_range(0, 99) >= vgap_pct);
            bus.cmd_i = (pend_cmds.size() != 0) ? pend_cmds[0] : '0;
            if (exp_q.size() != 0 && stall_left > 0) begin
                bus.yumi_i = 1'b0;
                stall_left--;
            end else begin
                bus.yumi_i = (exp_q.size() != 0) && ($urandom_range(0, 99) < yumi_pct);
            end
            @(negedge clk);
            checkOutput("v_o", 32'(bus.v_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                checkOutput("instr_o", bus.instr_o, exp_q[0].word);
                checkOutput("last_o", 32'(bus.last_o), 32'(exp_q[0].last));
            end
            checkOutput("error_o", 32'(bus.error_o), 32'(err_pending));
            if (bus.error_o) obs_errs++;
            err_pending = 1'b0;
            rdy_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.yumi_i);
            checkOutput("ready_o", 32'(bus.ready_o), 32'(rdy_exp));
            if (exp_q.size() != 0 && bus.yumi_i) begin
                obs_words.push_back(bus.instr_o);
                obs_last.push_back(bus.last_o);
                obs_cycle.push_back(cycle);
                void'(exp_q.pop_front());
            end
            if (bus.v_i && rdy_exp) modelCmd(pend_cmds.pop_front());
            @(posedge clk);
            #1;
            cyc++;
            cycle++;
        end
        bus.v_i    = 1'b0;
        bus.yumi_i = 1'b0;
        checkOutput("drained", 32'(pend_cmds.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        int start;
        reset_n     = 1'b0;
        bus.v_i     = 1'b0;
        bus.cmd_i   = '0;
        bus.yumi_i  = 1'b0;
        err_pending = 1'b0;
        clearObs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_v_o", 32'(bus.v_o), 32'd0);
        checkOutput("rst_last_o", 32'(bus.last_o), 32'd0);
        checkOutput("rst_error_o", 32'(bus.error_o), 32'd0);
        checkOutput("rst_instr_o", bus.instr_o, 32'd0);
        checkOutput("rst_ready_o", 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        $display("[TB] directed LI encodings");
        clearObs();
        pend_cmds.push_back(mkCmd(e_enc_li, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b0, 1'b0));
        applyStimulus(100, 0, 0, 50);
        checkObs("li_big_w0", 0, 32'h123452B7, 1'b0);
        checkObs("li_big_w1", 1, 32'h67828293, 1'b1);

        clearObs();
        pend_cmds.push_back(mkCmd(e_enc_li, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b0, 1'b0));
        applyStimulus(100, 0, 0, 50);
`ifdef VANILLA_INST_ENC_LI_SHORT_EN
        checkObs("li_wrap_w0", 0, 32'h80000093, 1'b1);
`else
        checkObs("li_wrap_w0", 0, 32'h000000B7, 1'b0);
        checkObs("li_wrap_w1", 1, 32'h80008093, 1'b1);
`endif

        clearObs();
        pend_cmds.push_back(mkCmd(e_enc_li, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0));
        applyStimulus(100, 0, 0, 50);
`ifdef VANILLA_INST_ENC_LI_SHORT_EN
        checkObs("li_small_w0", 0, 32'h00500093, 1'b1);
        checkOutput("li_small_count", 32'(obs_words.size()), 32'd1);
`else
        checkObs("li_small_w0", 0, 32'h000000B7, 1'b0);
        checkObs("li_small_w1", 1, 32'h00508093, 1'b1);
`endif

        $display("[TB] AMOSWAP held under back-pressure");
        clearObs();
        start = cycle;
        pend_cmds.push_back(mkCmd(e_enc_amoswap, 5'd3, 5'd4, 5'd5, 32'd0, 1'b1, 1'b0));
        applyStimulus(100, 0, 3, 50);
        checkObs("amo_word", 0, 32'h0C5221AF, 1'b1);
        if (obs_cycle.size() != 0) checkOutput("amo_hold_cycles", 32'(obs_cycle[0] - start), 32'd4);

        $display("[TB] illegal LW then back-to-back MRET");
        clearObs();
        pend_cmds.push_back(mkCmd(e_enc_lw, 5'd2, 5'd3, 5'd0, 32'd4096, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) pend_cmds.push_back(mkCmd(e_enc_mret, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0));
        applyStimulus(100, 0, 0, 50);
        checkOutput("lw_err_pulses", 32'(obs_errs), 32'd1);
        checkOutput("mret_count", 32'(obs_words.size()), 32'd3);
        for (int i = 0; i < 3; i++) checkObs("mret_word", i, 32'h30200073, 1'b1);
        if (obs_cycle.size() == 3) begin
            checkOutput("mret_gap0", 32'(obs_cycle[1] - obs_cycle[0]), 32'd1);
            checkOutput("mret_gap1", 32'(obs_cycle[2] - obs_cycle[1]), 32'd1);
        end

        $display("[TB] reset while LI first word is held");
        bus.v_i    = 1'b1;
        bus.cmd_i  = mkCmd(e_enc_li, 5'd7, 5'd0, 5'd0, 32'h12345678, 1'b0, 1'b0);
        bus.yumi_i = 1'b0;
        @(negedge clk);
        checkOutput("midli_ready_pre", 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.v_i = 1'b0;
        @(negedge clk);
        checkOutput("midli_v_o", 32'(bus.v_o), 32'd1);
        checkOutput("midli_lui", bus.instr_o, 32'h123453B7);
        checkOutput("midli_ready_held", 32'(bus.ready_o), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midli_rst_v_o", 32'(bus.v_o), 32'd0);
        checkOutput("midli_rst_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("midli_rst_last", 32'(bus.last_o), 32'd0);
        @(posedge clk);
        #1;
        clearObs();
        exp_q.delete();
        err_pending = 1'b0;
        pend_cmds.push_back(mkCmd(e_enc_mret, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0));
        applyStimulus(100, 0, 0, 50);
        checkOutput("post_rst_count", 32'(obs_words.size()), 32'd1);
        checkObs("post_rst_word", 0, 32'h30200073, 1'b1);

        $display("[TB] randomized command stream");
        clearObs();
        for (int i = 0; i < 300; i++) pend_cmds.push_back(randCmd());
        applyStimulus(60, 30, 0, 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
